// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences a shared-memory datapath, stalls on
// MemReady, flags unsupported opcodes and counts retired instructions.
module multicycle_control #(
    parameter int                  OP_WIDTH  = 6,
    parameter int                  CNT_WIDTH = 32,
    parameter logic [OP_WIDTH-1:0] OP_RTYPE  = 6'h00,
    parameter logic [OP_WIDTH-1:0] OP_LW     = 6'h23,
    parameter logic [OP_WIDTH-1:0] OP_SW     = 6'h2B,
    parameter logic [OP_WIDTH-1:0] OP_BEQ    = 6'h04,
    parameter logic [OP_WIDTH-1:0] OP_J      = 6'h02,
    parameter logic [OP_WIDTH-1:0] OP_ADDI   = 6'h08
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OP_WIDTH-1:0]  Opcode,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 PCWriteCond,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 MemtoReg,
    output logic                 RegDst,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [1:0]           PCSource,
    output logic                 IllegalOp,
    output logic [3:0]           State,
    output logic [CNT_WIDTH-1:0] InstrCount
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctl_t;

    state_t               state, next_state;
    ctl_t                 ctl, ctl_out;
    logic                 retire;
    logic                 illegal_d, illegal_q;
    logic [CNT_WIDTH-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state     <= next_state;
            illegal_q <= illegal_d;
            if (retire) count_q <= count_q + 1'b1;
        end
    end

    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        ctl        = '0;
        next_state = S_FETCH;
        retire     = 1'b0;
        illegal_d  = 1'b0;
        unique case (state)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'd1;
                ctl.ir_write  = MemReady;
                ctl.pc_write  = MemReady;
                next_state    = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ctl.alu_src_b = 2'd3;
                case (Opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDIEX;
                    default:      illegal_d  = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'd2;
                next_state    = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
                next_state   = MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                retire         = 1'b1;
            end
            S_MEMWR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
                retire        = MemReady;
                next_state    = MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = 2'd2;
                next_state    = S_ALUWB;
            end
            S_ALUWB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                retire        = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_op        = 2'd1;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = 2'd1;
                retire            = 1'b1;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = 2'd2;
                retire        = 1'b1;
            end
            S_ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'd2;
                next_state    = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctl.reg_write = 1'b1;
                retire        = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Reset forces every control line low immediately, without waiting for an edge.
    assign ctl_out     = rst ? ctl : '0;

    assign PCWrite     = ctl_out.pc_write;
    assign PCWriteCond = ctl_out.pc_write_cond;
    assign IorD        = ctl_out.iord;
    assign MemRead     = ctl_out.mem_read;
    assign MemWrite    = ctl_out.mem_write;
    assign IRWrite     = ctl_out.ir_write;
    assign MemtoReg    = ctl_out.mem_to_reg;
    assign RegDst      = ctl_out.reg_dst;
    assign RegWrite    = ctl_out.reg_write;
    assign ALUSrcA     = ctl_out.alu_src_a;
    assign ALUSrcB     = ctl_out.alu_src_b;
    assign ALUOp       = ctl_out.alu_op;
    assign PCSource    = ctl_out.pc_source;
    assign IllegalOp   = illegal_q;
    assign State       = state;
    assign InstrCount  = count_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM sequencing a shared-memory MIPS datapath (single memory, IR, A/B/ALUOut/MDR registers).
- Issues per-state datapath enables and mux selects from the latched opcode.
- Stalls on a memory ready handshake.
- Counts retired instructions.
- Replaces the single-cycle Control unit; existing ALU_Control is reused, driven from ALUOp.

Parameters:
- OP_WIDTH, 6, opcode field width
- CNT_WIDTH, 32, retired-instruction counter width
- OP_RTYPE, 6'h00, R-type opcode
- OP_LW, 6'h23, load word
- OP_SW, 6'h2B, store word
- OP_BEQ, 6'h04, branch equal
- OP_J, 6'h02, jump
- OP_ADDI, 6'h08, add immediate

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- Opcode  in  OP_WIDTH  IR[31:26]; valid from DECODE onward
- MemReady  in  1  memory completes current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load
- MemtoReg  out  1  register write data: 1=MDR, 0=ALUOut
- RegDst  out  1  write register: 1=rd, 0=rt
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- ALUOp  out  2  0=add, 1=sub, 2=funct-decoded
- PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target
- IllegalOp  out  1  one-cycle pulse: unsupported opcode
- State  out  4  current state encoding (debug)
- InstrCount  out  CNT_WIDTH  retired instructions

Behaviour:
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11
- Reset (rst=0, asynchronous):
  - State=FETCH, InstrCount=0, IllegalOp=0.
  - All other outputs 0 while rst=0, overriding FETCH decode.
  - First FETCH decode one cycle after rst deasserts; no partial instruction survives reset mid-operation.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0.
  - IRWrite=1 and PCWrite=1 only in a cycle with MemReady=1; then go to DECODE.
  - Otherwise hold FETCH with MemRead held high.
- DECODE:
  - ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target into ALUOut).
  - Next state by Opcode: LW/SW→MEMADR, RTYPE→EXEC, BEQ→BRANCH, J→JUMP, ADDI→ADDIEX.
  - Any other opcode → FETCH; IllegalOp registered high for exactly the next cycle; InstrCount unchanged.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. LW→MEMRD, SW→MEMWR.
- MEMRD: MemRead=1, IorD=1. Hold until MemReady=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Then FETCH; retire.
- MEMWR: MemWrite=1, IorD=1. Hold until MemReady=1, then FETCH; retire on the MemReady cycle.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2. Then ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Then FETCH; retire.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1. Then FETCH; retire.
- JUMP: PCWrite=1, PCSource=2. Then FETCH; retire.
- ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Then ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Then FETCH; retire.
- Unlisted outputs are 0 in every state.
- Outputs are combinational from the state register. Exceptions: IRWrite/PCWrite in FETCH and the MEMWR/MEMRD exits, which also depend on MemReady.
- MemRead and MemWrite are never high in the same cycle.
- Latency with MemReady tied to 1 (cycles per instruction): LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3. Each memory wait cycle adds 1.
- InstrCount: +1 on the clock edge leaving a retiring state; wraps from all-ones to 0.
- Opcode is sampled only in DECODE and MEMADR; changes at other times are ignored.
- Unreachable encodings 12–15 → FETCH on the next edge, all outputs 0.

Test Plan:
- Reset, then MemReady=1 with LW (6'h23) → states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; InstrCount=1.
- R-type then BEQ, MemReady=1 → 4 + 3 cycles; ALUOp=2 in EXEC; PCWriteCond=1 only in BRANCH; InstrCount=2.
- SW with MemReady low 3 cycles in MEMWR → MemWrite high 4 consecutive cycles, IorD=1; exits to FETCH after the MemReady cycle; InstrCount +1.
- FETCH with MemReady low 2 cycles → MemRead=1 throughout; IRWrite/PCWrite pulse once, on the third cycle only.
- Opcode 6'h3F in DECODE → next state FETCH; IllegalOp high exactly 1 cycle; InstrCount unchanged.
- rst pulled low mid-MEMRD, no clock edge → State=0 and all outputs 0 immediately; after release, clean FETCH; InstrCount=0.
